// File: rtl/rx_fifo_ctrl.sv
// Receive FIFO for one UART channel, sitting between the RX deserializer and
// the CPU register interface. Each entry holds a character plus its parity,
// framing and break flags. The FIFO also provides:
//   - show-ahead read port (head entry visible without a pop),
//   - sticky overrun flag for characters dropped while full,
//   - trigger-level interrupt on occupancy,
//   - character-timeout interrupt when data sits idle in the FIFO,
//   - synchronous flush,
//   - summary flag saying whether any stored entry carries an error.
// DEPTH must be a power of two and at least 2. The pointers carry one extra
// bit so that full and empty can be told apart.
module rx_fifo_ctrl #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ERR_W  = 3,
    parameter int TO_W   = 8,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ERR_W-1:0]  wr_err,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic [ERR_W-1:0]  rd_err,
    input  logic [CNT_W-1:0]  trig_level,
    input  logic [TO_W-1:0]   timeout_cycles,
    input  logic              overrun_clr,
    output logic [CNT_W-1:0]  count,
    output logic              empty,
    output logic              full,
    output logic              overrun,
    output logic              err_in_fifo,
    output logic              trig_irq,
    output logic              timeout_irq
);

    localparam int ADDR_W = CNT_W - 1;

    // One stored character together with its error flags.
    typedef struct packed {
        logic [ERR_W-1:0]  err;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t            mem [DEPTH];
    entry_t            head;

    logic [CNT_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  err_cnt;
    logic [TO_W-1:0]   idle_cnt;
    logic              overrun_q;
    logic              timeout_q;

    logic              pop_ok;
    logic              push;
    logic              pop;
    logic              drop;
    logic              err_inc;
    logic              err_dec;
    logic              idle_clr;

    // ------------------------------------------------------------------
    // Occupancy and status derived from the registered pointers. All of
    // these follow rst_n immediately because the pointers reset
    // asynchronously.
    // ------------------------------------------------------------------
    assign count = wr_ptr - rd_ptr;
    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));

    // Show-ahead head entry; forced to zero while nothing is stored so stale
    // memory contents never leak to the CPU.
    assign head    = mem[rd_ptr[ADDR_W-1:0]];
    assign rd_data = empty ? '0 : head.data;
    assign rd_err  = empty ? '0 : head.err;

    assign overrun     = overrun_q;
    assign err_in_fifo = (err_cnt != '0);
    assign timeout_irq = timeout_q;

    // Trigger compares the registered count; a level above DEPTH can never be
    // reached, so it simply never fires.
    assign trig_irq = (trig_level != '0) && (count >= trig_level);

    // Decode the per-cycle transfer: flush discards both sides, a pop needs
    // data, and a push into a full FIFO is only legal when a pop frees a slot
    // in the same cycle.
    // NOTE: every signal driven from always_comb gets a default first, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        pop_ok   = 1'b0;
        push     = 1'b0;
        pop      = 1'b0;
        drop     = 1'b0;
        err_inc  = 1'b0;
        err_dec  = 1'b0;
        idle_clr = 1'b0;

        pop_ok = rd_en && !empty;
        if (!flush) begin
            pop  = pop_ok;
            push = wr_en && (!full || pop_ok);
            drop = wr_en && full && !pop_ok;
        end

        err_inc  = push && (|wr_err);
        err_dec  = pop && (|head.err);
        idle_clr = flush || push || pop || empty;
    end

    // Storage array: written on an accepted push only.
    // NOTE: the memory has no reset; empty masks the read port, so stale
    // contents are never observable and the array can map onto plain RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[ADDR_W-1:0]] <= '{err: wr_err, data: wr_data};
        end
    end

    // Read and write pointers; flush rewinds both to zero.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + CNT_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + CNT_W'(1);
            end
        end
    end

    // Count of stored entries carrying any error flag; a push and pop of
    // erroneous entries in the same cycle cancel out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (flush) begin
            err_cnt <= '0;
        end else begin
            case ({err_inc, err_dec})
                2'b10:   err_cnt <= err_cnt + CNT_W'(1);
                2'b01:   err_cnt <= err_cnt - CNT_W'(1);
                default: err_cnt <= err_cnt;
            endcase
        end
    end

    // Sticky overrun: a fresh drop wins over a simultaneous clear, and flush
    // deliberately leaves the flag alone so software still sees the loss.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun_q <= 1'b0;
        end else if (drop) begin
            overrun_q <= 1'b1;
        end else if (overrun_clr) begin
            overrun_q <= 1'b0;
        end
    end

    // Character timeout: count idle cycles while data waits, and raise the
    // interrupt once the count reaches the programmed threshold. Any traffic,
    // a flush or an empty FIFO restarts the measurement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt  <= '0;
            timeout_q <= 1'b0;
        end else if (idle_clr) begin
            idle_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (idle_cnt != '1) begin
                idle_cnt <= idle_cnt + TO_W'(1);
            end
            if (timeout_cycles == '0) begin
                timeout_q <= 1'b0;
            end else if (idle_cnt == timeout_cycles - TO_W'(1)) begin
                timeout_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rx_fifo_ctrl.sv
// Self-checking bench for rx_fifo_ctrl: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_rx_fifo_ctrl;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int ERR_W  = 3;
    localparam int TO_W   = 8;
    localparam int CNT_W  = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [ERR_W-1:0]  err;
        logic [DATA_W-1:0] data;
    } ent_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              flush;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic [ERR_W-1:0]  wr_err;
    logic              rd_en;
    logic [DATA_W-1:0] rd_data;
    logic [ERR_W-1:0]  rd_err;
    logic [CNT_W-1:0]  trig_level;
    logic [TO_W-1:0]   timeout_cycles;
    logic              overrun_clr;
    logic [CNT_W-1:0]  count;
    logic              empty;
    logic              full;
    logic              overrun;
    logic              err_in_fifo;
    logic              trig_irq;
    logic              timeout_irq;

    // Reference model state
    ent_t m_q[$];
    bit   m_ovr;
    int   m_idle;

    int   checks = 0;
    int   errors = 0;

    rx_fifo_ctrl #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .ERR_W(ERR_W), .TO_W(TO_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .wr_en(wr_en), .wr_data(wr_data), .wr_err(wr_err),
        .rd_en(rd_en), .rd_data(rd_data), .rd_err(rd_err),
        .trig_level(trig_level), .timeout_cycles(timeout_cycles),
        .overrun_clr(overrun_clr), .count(count), .empty(empty), .full(full),
        .overrun(overrun), .err_in_fifo(err_in_fifo), .trig_irq(trig_irq),
        .timeout_irq(timeout_irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare every output against the model's view of the FIFO.
    task automatic check_all(input string tag);
        int   n;
        bit   any_err;
        n = m_q.size();
        any_err = 1'b0;
        foreach (m_q[i]) if (m_q[i].err != '0) any_err = 1'b1;
        check({tag, ".count"},   32'(count),       32'(n));
        check({tag, ".empty"},   32'(empty),       32'(n == 0));
        check({tag, ".full"},    32'(full),        32'(n == DEPTH));
        check({tag, ".rd_data"}, 32'(rd_data),     (n != 0) ? 32'(m_q[0].data) : 32'd0);
        check({tag, ".rd_err"},  32'(rd_err),      (n != 0) ? 32'(m_q[0].err)  : 32'd0);
        check({tag, ".overrun"}, 32'(overrun),     32'(m_ovr));
        check({tag, ".err_in"},  32'(err_in_fifo), 32'(any_err));
        check({tag, ".trig"},    32'(trig_irq),    32'((trig_level != 0) && (n >= int'(trig_level))));
        check({tag, ".tmo"},     32'(timeout_irq),
              32'((timeout_cycles != 0) && (n != 0) && (m_idle >= int'(timeout_cycles))));
    endtask

    // Drive one cycle of stimulus, advance the model across the edge, then
    // compare just after the edge.
    task automatic tick(input bit wr, input logic [DATA_W-1:0] d, input logic [ERR_W-1:0] e,
                        input bit rd, input bit fl, input bit oc);
        int  n;
        bit  do_pop, do_push, do_drop;
        wr_en = wr; wr_data = d; wr_err = e; rd_en = rd; flush = fl; overrun_clr = oc;
        @(posedge clk);
        n = m_q.size();
        if (fl) begin
            m_q.delete();
            m_idle = 0;
            m_ovr  = m_ovr && !oc;
        end else begin
            do_pop  = rd && (n > 0);
            do_push = wr && ((n < DEPTH) || do_pop);
            do_drop = wr && !do_push;
            if (do_pop)  void'(m_q.pop_front());
            if (do_push) m_q.push_back('{err: e, data: d});
            m_ovr = do_drop || (m_ovr && !oc);
            if (do_push || do_pop || n == 0) m_idle = 0;
            else m_idle++;
        end
        #1;
        check_all("tick");
    endtask

    task automatic idle_tick();
        tick(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; wr_en = 1'b0; wr_data = '0; wr_err = '0;
        rd_en = 1'b0; trig_level = '0; timeout_cycles = '0; overrun_clr = 1'b0;
        m_ovr = 1'b0; m_idle = 0;
        #12 rst_n = 1'b1;
        #1;

        // Reset state
        check_all("reset");
        check("reset.empty", 32'(empty), 32'd1);

        // Fill, overrun on the 17th push, drain in order
        for (int i = 0; i < 16; i++) tick(1'b1, 8'(i), '0, 1'b0, 1'b0, 1'b0);
        check("fill.full", 32'(full), 32'd1);
        check("fill.count", 32'(count), 32'd16);
        tick(1'b1, 8'hAA, '0, 1'b0, 1'b0, 1'b0);
        check("ovr.set", 32'(overrun), 32'd1);
        check("ovr.count", 32'(count), 32'd16);
        for (int i = 0; i < 16; i++) begin
            check("drain.order", 32'(rd_data), 32'(i));
            tick(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        end
        check("drain.empty", 32'(empty), 32'd1);
        tick(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);   // pop while empty is ignored; clear overrun
        check("ovr.clr", 32'(overrun), 32'd0);

        // Full with simultaneous push and pop
        for (int i = 0; i < 16; i++) tick(1'b1, 8'(8'h10 + i), '0, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 8'h55, '0, 1'b1, 1'b0, 1'b0);
        check("pp.count", 32'(count), 32'd16);
        check("pp.ovr", 32'(overrun), 32'd0);
        for (int i = 0; i < 15; i++) tick(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        check("pp.head", 32'(rd_data), 32'h55);
        tick(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

        // Empty with simultaneous push and pop: only the push happens
        tick(1'b1, 8'h33, '0, 1'b1, 1'b0, 1'b0);
        check("ep.count", 32'(count), 32'd1);
        tick(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

        // Trigger level
        trig_level = CNT_W'(4);
        for (int i = 0; i < 3; i++) tick(1'b1, 8'(i), '0, 1'b0, 1'b0, 1'b0);
        check("trig.below", 32'(trig_irq), 32'd0);
        tick(1'b1, 8'h03, '0, 1'b0, 1'b0, 1'b0);
        check("trig.at", 32'(trig_irq), 32'd1);
        tick(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        check("trig.pop", 32'(trig_irq), 32'd0);
        for (int i = 0; i < 3; i++) tick(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        trig_level = CNT_W'(17);
        for (int i = 0; i < 16; i++) tick(1'b1, 8'(i), '0, 1'b0, 1'b0, 1'b0);
        check("trig.gt_depth", 32'(trig_irq), 32'd0);
        tick(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        trig_level = '0;

        // Character timeout: rises exactly 10 cycles after the push edge
        timeout_cycles = TO_W'(10);
        tick(1'b1, 8'h77, '0, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k < 10; k++) begin
            idle_tick();
            check("tmo.early", 32'(timeout_irq), 32'd0);
        end
        idle_tick();
        check("tmo.rise", 32'(timeout_irq), 32'd1);
        idle_tick();
        check("tmo.hold", 32'(timeout_irq), 32'd1);
        tick(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        check("tmo.pop_clr", 32'(timeout_irq), 32'd0);
        timeout_cycles = '0;
        tick(1'b1, 8'h78, '0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 20; k++) idle_tick();
        check("tmo.disabled", 32'(timeout_irq), 32'd0);
        tick(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

        // Error summary flag
        tick(1'b1, 8'h41, 3'b000, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 8'h42, 3'b010, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 8'h43, 3'b000, 1'b0, 1'b0, 1'b0);
        check("err.set", 32'(err_in_fifo), 32'd1);
        tick(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        check("err.after41", 32'(err_in_fifo), 32'd1);
        check("err.rd_err", 32'(rd_err), 32'b010);
        tick(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        check("err.after42", 32'(err_in_fifo), 32'd0);
        tick(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

        // Flush keeps overrun; push in the flush cycle is discarded
        for (int i = 0; i < 17; i++) tick(1'b1, 8'(i), 3'(i % 2), 1'b0, 1'b0, 1'b0);
        tick(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) tick(1'b1, 8'(i), 3'b100, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 8'hEE, 3'b001, 1'b1, 1'b1, 1'b0);
        check("fl.count", 32'(count), 32'd0);
        check("fl.empty", 32'(empty), 32'd1);
        check("fl.err", 32'(err_in_fifo), 32'd0);
        check("fl.ovr", 32'(overrun), 32'd1);
        tick(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        check("fl.ovr_clr", 32'(overrun), 32'd0);

        // Asynchronous reset in the middle of a burst
        for (int i = 0; i < 6; i++) tick(1'b1, 8'(8'hC0 + i), 3'b001, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 8'hC6, '0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 17; i++) tick(1'b1, 8'(i), 3'b001, 1'b0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        m_q.delete(); m_ovr = 1'b0; m_idle = 0;
        check_all("arst");
        check("arst.empty", 32'(empty), 32'd1);
        check("arst.ovr", 32'(overrun), 32'd0);
        #2 rst_n = 1'b1;

        // Randomized traffic, sparse then dense
        timeout_cycles = TO_W'(3);
        for (int i = 0; i < 600; i++) begin
            bit dense;
            dense = (i >= 300);
            if (i % 50 == 0) trig_level = CNT_W'($urandom_range(0, DEPTH + 1));
            tick(dense ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0),
                 8'($urandom_range(0, 255)),
                 ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b000,
                 dense ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 59) == 0),
                 ($urandom_range(0, 19) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
